// File: rtl/pdat_rx_pkg.sv
// Shared definitions for the parallel-data capture receiver.
// Holds the FSM state encoding and the synchronizer depth floor.
package pdat_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int N_SYN_MIN = 2;

endpackage

// File: rtl/pdat_rx_buf.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// The read register is cleared by reset so the popped-word output starts at zero.
module pdat_rx_buf #(
   parameter int W  = 16,
   parameter int AW = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [W-1:0]  rd_data_o
);

   logic [W-1:0] mem_q [2**AW];
   logic [W-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)     rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/funcmod_pdat_rx.sv
// Captures words from an external parallel converter on edges of its data clock,
// stores them in a FIFO and lets the host pop them in the system clock domain.
module funcmod_pdat_rx
   import pdat_rx_pkg::*;
#(
   parameter int W_DAT = 16,
   parameter int AW    = 8,
   parameter int N_SYN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic             abort,
   input  logic [AW:0]      n_smp,
   input  logic             clk_pol,
   input  logic             ext_clk,
   input  logic             ext_frm,
   input  logic [W_DAT-1:0] ext_dat,
   input  logic             rd_en,
   output logic [W_DAT-1:0] rd_dat,
   output logic             rd_vld,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [AW:0]      level,
   output logic [7:0]       edg_cnt
);

   localparam int          NS    = (N_SYN < N_SYN_MIN) ? N_SYN_MIN : N_SYN;
   localparam int          SW    = W_DAT + 2;
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [SW-1:0]    sync_q [NS];
   logic             clk_dly_q;
   logic             edge_det, frm_s;
   logic [W_DAT-1:0] dat_s;

   state_e        st_q, st_d;
   logic [AW:0]   cnt_q, cnt_d, level_q, level_d, target;
   logic [AW-1:0] wptr_q, rptr_q;
   logic [7:0]    edg_q, edg_d;
   logic          done_q, done_d, ovf_q, ovf_d, rd_vld_q;
   logic          accept, full, we, re;

   // Clock, frame and data share one chain so they stay cycle-aligned;
   // only the clock bit needs the extra stage for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NS; i++) sync_q[i] <= '0;
         clk_dly_q <= 1'b0;
      end else begin
         sync_q[0] <= {ext_clk, ext_frm, ext_dat};
         for (int i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
         clk_dly_q <= sync_q[NS-1][SW-1];
      end
   end

   assign edge_det = (sync_q[NS-1][SW-1] ^ clk_pol) & ~(clk_dly_q ^ clk_pol);
   assign frm_s    = sync_q[NS-1][SW-2];
   assign dat_s    = sync_q[NS-1][W_DAT-1:0];
   assign target   = (n_smp == '0) ? DEPTH : n_smp;

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      ovf_d   = ovf_q;
      edg_d   = edg_q;
      accept  = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (arm) begin
               st_d   = ST_WAIT;
               cnt_d  = '0;
               done_d = 1'b0;
               ovf_d  = 1'b0;
               edg_d  = '0;
            end
         end
         ST_WAIT, ST_CAPT: begin
            if (abort) begin
               st_d = ST_IDLE;
            end else if (edge_det) begin
               edg_d = sat_inc8(edg_q);
               if (frm_s) begin
                  accept = 1'b1;
                  cnt_d  = cnt_q + 1'b1;
                  if (cnt_d == target) begin
                     st_d   = ST_DONE;
                     done_d = 1'b1;
                  end else begin
                     st_d = ST_CAPT;
                  end
               end else if (st_q == ST_CAPT) begin
                  st_d   = ST_DONE;
                  done_d = 1'b1;
               end
            end
         end
         ST_DONE: st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase
      // A word that arrives while full is dropped but still counts toward n_smp.
      full = (level_q == DEPTH);
      we   = accept & ~full;
      if (accept && full) ovf_d = 1'b1;
      re      = rd_en && (level_q != '0);
      level_d = level_q + {{AW{1'b0}}, we} - {{AW{1'b0}}, re};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q     <= ST_IDLE;
         cnt_q    <= '0;
         level_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         edg_q    <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         edg_q    <= edg_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         rd_vld_q <= re;
         if (we) wptr_q <= wptr_q + 1'b1;
         if (re) rptr_q <= rptr_q + 1'b1;
      end
   end

   pdat_rx_buf #(
      .W  (W_DAT),
      .AW (AW)
   ) u_buf (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .wr_en_i   (we),
      .wr_addr_i (wptr_q),
      .wr_data_i (dat_s),
      .rd_en_i   (re),
      .rd_addr_i (rptr_q),
      .rd_data_o (rd_dat)
   );

   assign rd_vld  = rd_vld_q;
   assign busy    = (st_q == ST_WAIT) || (st_q == ST_CAPT);
   assign done    = done_q;
   assign ovf     = ovf_q;
   assign level   = level_q;
   assign edg_cnt = edg_q;

endmodule

// File: tb/tb_funcmod_pdat_rx.sv
// Bench for funcmod_pdat_rx: a default-size instance and a 4-deep instance share
// the converter stimulus; a queue-based model predicts what the large one holds.
module tb_funcmod_pdat_rx;

   localparam int AW  = 8;
   localparam int AWS = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm = 1'b0, abort = 1'b0, clk_pol = 1'b0;
   logic          ext_clk = 1'b0, ext_frm = 1'b0;
   logic [15:0]   ext_dat = '0;
   logic [AW:0]   n_smp = '0;
   logic          rd_en = 1'b0;
   logic [15:0]   rd_dat;
   logic          rd_vld, busy, done, ovf;
   logic [AW:0]   level;
   logic [7:0]    edg_cnt;

   logic          arm_s = 1'b0, rd_en_s = 1'b0;
   logic [AWS:0]  n_smp_s = '0;
   logic [15:0]   rd_dat_s;
   logic          rd_vld_s, busy_s, done_s, ovf_s;
   logic [AWS:0]  level_s;
   logic [7:0]    edg_cnt_s;

   int n_pass = 0;
   int n_total = 0;

   // reference model state for the large instance
   logic [15:0] model_q [$];
   int  m_cnt, m_target, m_edges;
   bit  m_active, m_started, m_done, m_ovf;

   funcmod_pdat_rx #(.W_DAT(16), .AW(AW), .N_SYN(3)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .n_smp(n_smp),
      .clk_pol(clk_pol), .ext_clk(ext_clk), .ext_frm(ext_frm), .ext_dat(ext_dat),
      .rd_en(rd_en), .rd_dat(rd_dat), .rd_vld(rd_vld), .busy(busy), .done(done),
      .ovf(ovf), .level(level), .edg_cnt(edg_cnt)
   );

   funcmod_pdat_rx #(.W_DAT(16), .AW(AWS), .N_SYN(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .arm(arm_s), .abort(abort), .n_smp(n_smp_s),
      .clk_pol(clk_pol), .ext_clk(ext_clk), .ext_frm(ext_frm), .ext_dat(ext_dat),
      .rd_en(rd_en_s), .rd_dat(rd_dat_s), .rd_vld(rd_vld_s), .busy(busy_s), .done(done_s),
      .ovf(ovf_s), .level(level_s), .edg_cnt(edg_cnt_s)
   );

   always #5 clk = ~clk;

   // One converter clock period (8 system clocks). Data is junk just after the
   // non-capturing transition and valid around the capturing one. With pop set,
   // rd_en is raised for the cycle in which the captured word is written.
   task automatic ext_cycle(input logic frm, input logic [15:0] dat, input logic pop);
      ext_clk = clk_pol;
      ext_frm = frm;
      ext_dat = ~dat;
      repeat (2) @(negedge clk);
      ext_dat = dat;
      repeat (2) @(negedge clk);
      ext_clk = ~clk_pol;
      repeat (3) @(negedge clk);
      rd_en = pop;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic model_arm(input int n);
      m_active = 1; m_started = 0; m_cnt = 0; m_done = 0; m_ovf = 0; m_edges = 0;
      m_target = (n == 0) ? 256 : n;
   endtask

   task automatic model_edge(input logic frm, input logic [15:0] dat);
      if (!m_active) return;
      if (m_edges < 255) m_edges++;
      if (!frm) begin
         if (m_started) begin m_active = 0; m_done = 1; end
         return;
      end
      m_started = 1;
      m_cnt++;
      if (model_q.size() < 256) model_q.push_back(dat);
      else m_ovf = 1;
      if (m_cnt == m_target) begin m_active = 0; m_done = 1; end
   endtask

   task automatic edge_big(input logic frm, input logic [15:0] dat, input logic pop);
      ext_cycle(frm, dat, pop);
      model_edge(frm, dat);
   endtask

   task automatic arm_big(input int n);
      n_smp = n[AW:0];
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      model_arm(n);
   endtask

   task automatic set_pol(input logic p);
      clk_pol = p;
      ext_clk = p;
      ext_frm = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic pop_big(output logic [15:0] d, output logic v);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      d = rd_dat;
      v = rd_vld;
   endtask

   task automatic pop_small(output logic [15:0] d, output logic v);
      rd_en_s = 1'b1;
      @(negedge clk);
      rd_en_s = 1'b0;
      d = rd_dat_s;
      v = rd_vld_s;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_total++; if ({busy, done, ovf, rd_vld} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {busy, done, ovf, rd_vld}); else n_pass++;
      n_total++; if (level !== '0) $display("FAIL reset_level: got %0d expected 0", level); else n_pass++;
      n_total++; if (edg_cnt !== 8'd0) $display("FAIL reset_edg: got %0d expected 0", edg_cnt); else n_pass++;
      n_total++; if (rd_dat !== 16'd0) $display("FAIL reset_rd_dat: got %h expected 0000", rd_dat); else n_pass++;
   endtask

   task automatic test_basic(input logic pol);
      logic [15:0] d, e;
      logic v;
      set_pol(pol);
      arm_big(4);
      for (int k = 1; k <= 4; k++) edge_big(1'b1, 16'(k), 1'b0);
      repeat (8) @(negedge clk);
      n_total++; if (level !== 9'(model_q.size())) $display("FAIL basic%0d_level: got %0d expected %0d", pol, level, model_q.size()); else n_pass++;
      n_total++; if (done !== m_done || busy !== m_active) $display("FAIL basic%0d_done_busy: got %b%b expected %b%b", pol, done, busy, m_done, m_active); else n_pass++;
      n_total++; if (edg_cnt !== 8'(m_edges)) $display("FAIL basic%0d_edg: got %0d expected %0d", pol, edg_cnt, m_edges); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         pop_big(d, v);
         e = model_q.pop_front();
         n_total++; if (v !== 1'b1 || d !== e) $display("FAIL basic%0d_pop%0d: got vld=%b %h expected vld=1 %h", pol, k, v, d, e); else n_pass++;
      end
      set_pol(1'b0);
   endtask

   task automatic test_frame_drop();
      logic [15:0] d, e;
      logic v;
      arm_big(10);
      for (int k = 0; k < 3; k++) edge_big(1'b1, 16'($urandom), 1'b0);
      edge_big(1'b0, 16'($urandom), 1'b0);
      edge_big(1'b1, 16'($urandom), 1'b0);
      repeat (8) @(negedge clk);
      n_total++; if (level !== 9'(model_q.size())) $display("FAIL frm_level: got %0d expected %0d", level, model_q.size()); else n_pass++;
      n_total++; if (done !== m_done || busy !== 1'b0) $display("FAIL frm_done: got done=%b busy=%b expected done=%b busy=0", done, busy, m_done); else n_pass++;
      n_total++; if (edg_cnt !== 8'(m_edges)) $display("FAIL frm_edg: got %0d expected %0d", edg_cnt, m_edges); else n_pass++;
      while (model_q.size() > 0) begin
         pop_big(d, v);
         e = model_q.pop_front();
         n_total++; if (v !== 1'b1 || d !== e) $display("FAIL frm_pop: got vld=%b %h expected vld=1 %h", v, d, e); else n_pass++;
      end
   endtask

   task automatic test_abort();
      logic [15:0] d, e;
      logic v;
      arm_big(8);
      for (int k = 0; k < 2; k++) edge_big(1'b1, 16'($urandom), 1'b0);
      repeat (2) @(negedge clk);
      n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy); else n_pass++;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      m_active = 0;
      @(negedge clk);
      n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_state: got busy=%b done=%b expected 0 0", busy, done); else n_pass++;
      for (int k = 0; k < 2; k++) edge_big(1'b1, 16'($urandom), 1'b0);
      repeat (4) @(negedge clk);
      n_total++; if (level !== 9'(model_q.size())) $display("FAIL abort_level: got %0d expected %0d", level, model_q.size()); else n_pass++;
      while (model_q.size() > 0) begin
         pop_big(d, v);
         e = model_q.pop_front();
         n_total++; if (v !== 1'b1 || d !== e) $display("FAIL abort_pop: got vld=%b %h expected vld=1 %h", v, d, e); else n_pass++;
      end
   endtask

   task automatic test_rd_empty();
      logic [15:0] d;
      logic v;
      pop_big(d, v);
      n_total++; if (v !== 1'b0) $display("FAIL empty_vld: got %b expected 0", v); else n_pass++;
      n_total++; if (level !== '0) $display("FAIL empty_level: got %0d expected 0", level); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] d, e, w0, w1, w2;
      logic v;
      w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
      arm_big(3);
      edge_big(1'b1, w0, 1'b0);
      edge_big(1'b1, w1, 1'b1);
      e = model_q.pop_front();
      n_total++; if (rd_vld !== 1'b1 || rd_dat !== e) $display("FAIL b2b_pop: got vld=%b %h expected vld=1 %h", rd_vld, rd_dat, e); else n_pass++;
      n_total++; if (level !== 9'(model_q.size())) $display("FAIL b2b_level: got %0d expected %0d", level, model_q.size()); else n_pass++;
      edge_big(1'b1, w2, 1'b0);
      repeat (6) @(negedge clk);
      n_total++; if (done !== m_done || level !== 9'(model_q.size())) $display("FAIL b2b_end: got done=%b level=%0d expected %b %0d", done, level, m_done, model_q.size()); else n_pass++;
      while (model_q.size() > 0) begin
         pop_big(d, v);
         e = model_q.pop_front();
         n_total++; if (v !== 1'b1 || d !== e) $display("FAIL b2b_drain: got vld=%b %h expected vld=1 %h", v, d, e); else n_pass++;
      end
   endtask

   task automatic test_edge_sat();
      arm_big(5);
      for (int k = 0; k < 260; k++) edge_big(1'b0, 16'($urandom), 1'b0);
      repeat (2) @(negedge clk);
      n_total++; if (edg_cnt !== 8'(m_edges)) $display("FAIL sat_edg: got %0d expected %0d", edg_cnt, m_edges); else n_pass++;
      n_total++; if (busy !== 1'b1 || level !== '0) $display("FAIL sat_wait: got busy=%b level=%0d expected 1 0", busy, level); else n_pass++;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      m_active = 0;
      @(negedge clk);
      n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL sat_abort: got busy=%b done=%b expected 0 0", busy, done); else n_pass++;
   endtask

   task automatic test_small(input int n, input int n_edges);
      logic [15:0] d, v_dat [8];
      logic v;
      int kept, expect_edges;
      n_smp_s = n[AWS:0];
      arm_s = 1'b1;
      @(negedge clk);
      arm_s = 1'b0;
      for (int k = 0; k < n_edges; k++) begin
         v_dat[k] = 16'($urandom);
         ext_cycle(1'b1, v_dat[k], 1'b0);
      end
      repeat (8) @(negedge clk);
      expect_edges = (n == 0) ? 4 : n;
      kept = 4;
      n_total++; if (level_s !== 3'(kept)) $display("FAIL small%0d_level: got %0d expected %0d", n, level_s, kept); else n_pass++;
      n_total++; if (ovf_s !== (expect_edges > 4)) $display("FAIL small%0d_ovf: got %b expected %b", n, ovf_s, expect_edges > 4); else n_pass++;
      n_total++; if (done_s !== 1'b1 || busy_s !== 1'b0) $display("FAIL small%0d_done: got done=%b busy=%b expected 1 0", n, done_s, busy_s); else n_pass++;
      n_total++; if (edg_cnt_s !== 8'(expect_edges)) $display("FAIL small%0d_edg: got %0d expected %0d", n, edg_cnt_s, expect_edges); else n_pass++;
      for (int k = 0; k < kept; k++) begin
         pop_small(d, v);
         n_total++; if (v !== 1'b1 || d !== v_dat[k]) $display("FAIL small%0d_pop%0d: got vld=%b %h expected vld=1 %h", n, k, v, d, v_dat[k]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      arm_big(8);
      for (int k = 0; k < 2; k++) edge_big(1'b1, 16'($urandom) | 16'h0001, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_total++; if ({busy, done, ovf, rd_vld} !== 4'b0) $display("FAIL rstmid_flags: got %b expected 0000", {busy, done, ovf, rd_vld}); else n_pass++;
      n_total++; if (level !== '0 || edg_cnt !== 8'd0) $display("FAIL rstmid_counts: got level=%0d edg=%0d expected 0 0", level, edg_cnt); else n_pass++;
      n_total++; if (rd_dat !== 16'd0) $display("FAIL rstmid_rd_dat: got %h expected 0000", rd_dat); else n_pass++;
      rst_n = 1'b1;
      model_q.delete();
      m_active = 0;
      repeat (2) @(negedge clk);
      n_total++; if (busy !== 1'b0 || level !== '0) $display("FAIL rstmid_after: got busy=%b level=%0d expected 0 0", busy, level); else n_pass++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic(1'b0);
      test_basic(1'b1);
      test_frame_drop();
      test_abort();
      test_rd_empty();
      test_back_to_back();
      test_edge_sat();
      test_small(6, 6);
      test_small(0, 5);
      test_basic(1'b0);
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/funcmod_pdat_rx.md
FUNCMOD_PDAT_RX -- requirements
Module: funcmod_pdat_rx

Interface
REQ-001 SHALL expose parameter W_DAT, default 16, meaning parallel data width.
REQ-002 SHALL expose parameter AW, default 8, meaning capture buffer address width (depth 2^AW).
REQ-003 SHALL expose parameter N_SYN, default 3, meaning synchronizer depth for external inputs (min 2).
REQ-004 SHALL have ports:
  clk  in  1  system clock (only clock)
  rst_n  in  1  synchronous active-low reset
  arm  in  1  one-cycle pulse, start capture
  abort  in  1  one-cycle pulse, stop capture
  n_smp  in  AW+1  samples to capture, 0 = fill buffer
  clk_pol  in  1  1 = capture on falling edge of ext_clk
  ext_clk  in  1  asynchronous data clock from converter
  ext_frm  in  1  asynchronous frame-valid from converter
  ext_dat  in  W_DAT  asynchronous parallel data
  rd_en  in  1  pop one word
  rd_dat  out  W_DAT  popped word
  rd_vld  out  1  rd_dat valid
  busy  out  1  state is WAIT or CAPT
  done  out  1  sticky, capture finished
  ovf  out  1  sticky, sample dropped while buffer full
  level  out  AW+1  words in buffer
  edg_cnt  out  8  saturating count of detected ext_clk edges since arm

Function
REQ-005 SHALL pass ext_clk, ext_frm and every ext_dat bit through identical N_SYN-flop chains so all three stay cycle-aligned.
REQ-006 SHALL XOR the synchronized clock with clk_pol and flag an edge when the post-XOR value is 1 in chain stage N_SYN and 0 in stage N_SYN+1.
REQ-007 SHALL write the data value from the same chain stage as the clock sample that produced the edge.
REQ-008 SHALL implement FSM IDLE, WAIT, CAPT, DONE; reset state IDLE.
REQ-009 SHALL go IDLE->WAIT on arm, clearing done, ovf, edg_cnt and the sample counter; buffer contents and level are kept.
REQ-010 SHALL go WAIT->CAPT on the first edge with synchronized ext_frm=1, writing that word.
REQ-011 SHALL in CAPT write one word per edge while ext_frm=1; an edge with ext_frm=0 writes nothing and moves to DONE.
REQ-012 SHALL move to DONE on the edge that writes the n_smp-th word; with n_smp=0, the edge that writes word 2^AW.
REQ-013 SHALL in DONE assert done and return to IDLE the next cycle; done stays sticky until the next arm or reset.
REQ-014 SHALL ignore arm outside IDLE; abort in WAIT or CAPT goes to IDLE without setting done, and abort wins over a same-cycle edge.
REQ-015 SHALL, on an edge with the buffer full (level = 2^AW), drop the word, set ovf, and keep counting toward n_smp.
REQ-016 SHALL behave as FIFO: rd_en with level>0 gives rd_vld=1 and the head word on rd_dat one cycle later; rd_en with level=0 gives rd_vld=0 and no change.
REQ-017 SHALL, on a same-cycle write and pop, leave level unchanged; pointers wrap modulo 2^AW.
REQ-018 SHALL increment edg_cnt on every detected edge in WAIT or CAPT, saturating at 255.

Reset
REQ-019 SHALL on rst_n=0 at a clk edge set state IDLE, pointers and level 0, done=0, ovf=0, rd_vld=0, edg_cnt=0, rd_dat=0, and all synchronizer flops 0, including when reset occurs mid-capture.

Structure
REQ-020 SHALL place FSM state encoding and the N_SYN minimum in shared package pdat_rx_pkg.
REQ-021 SHALL use one sub-module, pdat_rx_buf: simple dual-port RAM with registered read.

Verification
REQ-022 SHALL cover: n_smp=4, pol=0, frm=1, ext_clk period 8 clk, dat 0x0001..0x0004 -> level=4, done=1, pops return 1,2,3,4.
REQ-023 SHALL cover: pol=1 and same stimulus -> words captured on falling edges, values match the data at each falling edge.
REQ-024 SHALL cover: AW=2, n_smp=6 -> ovf=1, level=4, first four words kept, done=1.
REQ-025 SHALL cover: frm drops after 3 edges with n_smp=10 -> level=3, done=1.
REQ-026 SHALL cover: abort after 2 edges -> IDLE, done=0, level=2; rst_n low mid-capture -> all outputs 0.
REQ-027 SHALL cover: rd_en at level=0 -> rd_vld=0; simultaneous write and pop -> level unchanged.
